// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell walks a WIDTH-bit operand pair LSB first.
// Optional macro SERIAL_ADD_SUB_EN adds a `sub` input for two's-complement subtraction.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             b_bit;
    logic             start_carry;
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] psum_shift;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_q, sub_d;

    // Subtraction is a + ~b + 1: invert B into the cell and seed the carry with 1.
    assign b_bit       = b_q[0] ^ sub_q;
    assign start_carry = sub ? 1'b1 : c_in;
`else
    assign b_bit       = b_q[0];
    assign start_carry = c_in;
`endif

    full_adder u_fa (
        .a_i (a_q[0]),
        .b_i (b_bit),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // NOTE: every variable gets a default at the top of the block, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        psum_d     = psum_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
`ifdef SERIAL_ADD_SUB_EN
        sub_d      = sub_q;
`endif
        psum_shift             = psum_q >> 1;
        psum_shift[WIDTH-1]    = fa_s;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = start_carry;
                    cnt_d   = '0;
`ifdef SERIAL_ADD_SUB_EN
                    sub_d   = sub;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                psum_d  = psum_shift;
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = psum_shift;
                    cout_d  = fa_c;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values, matching the hardware.
    // NOTE: datapath registers are reset along with the FSM; there are only a handful, and it keeps the post-reset state fully defined.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign c_out = cout_q;

endmodule
